// File: rtl/spi_sched_pkg.sv
// Shared types and constants for the SPI request scheduler: FSM states,
// SPI command bytes, frame length, request/response field positions.
package spi_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SEND,
        ST_WAIT,
        ST_HOLD,
        ST_ACK,
        ST_RELEASE
    } state_t;

    localparam logic [7:0]  CMD_RD       = 8'h03;
    localparam logic [7:0]  CMD_WR       = 8'h02;
    localparam int unsigned FRAME_BYTES  = 6;

    localparam int unsigned REQ_RD_BIT   = 0;
    localparam int unsigned REQ_WDAT_LSB = 1;
    localparam int unsigned REQ_ADR_LSB  = 33;
    localparam int unsigned RSP_ADR_LSB  = 0;
    localparam int unsigned RSP_RDAT_LSB = 8;

    // Byte shifted out at frame position idx; reads clock out zeros as data.
    function automatic logic [7:0] frame_byte(input logic [2:0]  idx,
                                              input logic        rd,
                                              input logic [7:0]  adr,
                                              input logic [31:0] wdat);
        case (idx)
            3'd0:    frame_byte = rd ? CMD_RD : CMD_WR;
            3'd1:    frame_byte = adr;
            3'd2:    frame_byte = rd ? 8'h00 : wdat[31:24];
            3'd3:    frame_byte = rd ? 8'h00 : wdat[23:16];
            3'd4:    frame_byte = rd ? 8'h00 : wdat[15:8];
            3'd5:    frame_byte = rd ? 8'h00 : wdat[7:0];
            default: frame_byte = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/spi_sched_cnt.sv
// Loadable down-counter with zero flag; shared by the CS setup, CS hold
// and per-byte timeout intervals of the scheduler.
module spi_sched_cnt #(
    parameter int unsigned W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/spi_req_sched.sv
// Request scheduler: frames one buffered request into CS + six SPI bytes.
// Optional per-byte timeout/abort enabled by defining SPI_SCHED_TIMEOUT_EN.
module spi_req_sched
    import spi_sched_pkg::*;
#(
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2,
    parameter int unsigned TIMEOUT  = 1023
) (
    input  logic        WB_CLK_I,
    input  logic        WB_RST_I,
    input  logic        BUF_STATUS,
    input  logic [40:0] BUF_DATA_I,
    output logic [40:0] BUF_DATA_O,
    output logic        BUF_ACK,
    output logic        SPI_START,
    output logic [7:0]  SPI_TX,
    input  logic [7:0]  SPI_RX,
    input  logic        SPI_DONE,
    output logic        SPI_CS_N,
    output logic        ERR
);

    localparam int unsigned CNT_MAX =
        (TIMEOUT > CS_SETUP) ? ((TIMEOUT > CS_HOLD) ? TIMEOUT : CS_HOLD)
                             : ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
    localparam int unsigned CW = $clog2(CNT_MAX + 1);

    state_t          r_state, w_next;
    logic [2:0]      r_idx;
    logic [7:0]      r_adr;
    logic [31:0]     r_wdat;
    logic            r_rd;
    logic [31:0]     r_rdata;
    logic [40:0]     r_dout;
    logic            w_cnt_load, w_cnt_dec, w_cnt_zero;
    logic [CW-1:0]   w_cnt_val;
    logic            w_cs_n, w_start, w_ack, w_last;
    logic [7:0]      w_tx;
`ifdef SPI_SCHED_TIMEOUT_EN
    logic            r_err;
    logic            w_timeout;
`endif

    assign w_last = (r_idx == 3'(FRAME_BYTES - 1));

    spi_sched_cnt #(.W(CW)) u_cnt (
        .i_clk  (WB_CLK_I),
        .i_rst  (WB_RST_I),
        .i_load (w_cnt_load),
        .i_val  (w_cnt_val),
        .i_dec  (w_cnt_dec),
        .o_zero (w_cnt_zero)
    );

    always_ff @(posedge WB_CLK_I) begin
        if (WB_RST_I) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_load = 1'b0;
        w_cnt_val  = '0;
        w_cnt_dec  = 1'b0;
        w_cs_n     = 1'b1;
        w_start    = 1'b0;
        w_tx       = '0;
        w_ack      = 1'b0;
`ifdef SPI_SCHED_TIMEOUT_EN
        w_timeout  = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (BUF_STATUS) begin
                    w_next     = ST_SETUP;
                    w_cnt_load = 1'b1;
                    w_cnt_val  = CW'(CS_SETUP - 1);
                end
            end
            ST_SETUP: begin
                w_cs_n = 1'b0;
                if (w_cnt_zero) w_next = ST_SEND;
                else            w_cnt_dec = 1'b1;
            end
            ST_SEND: begin
                w_cs_n     = 1'b0;
                w_start    = 1'b1;
                w_tx       = frame_byte(r_idx, r_rd, r_adr, r_wdat);
                w_next     = ST_WAIT;
                w_cnt_load = 1'b1;
                w_cnt_val  = CW'(TIMEOUT - 1);
            end
            ST_WAIT: begin
                w_cs_n = 1'b0;
                // A DONE coinciding with counter expiry completes the byte normally.
                if (SPI_DONE) begin
                    if (w_last) begin
                        w_next     = ST_HOLD;
                        w_cnt_load = 1'b1;
                        w_cnt_val  = CW'(CS_HOLD - 1);
                    end else begin
                        w_next = ST_SEND;
                    end
                end
`ifdef SPI_SCHED_TIMEOUT_EN
                else if (w_cnt_zero) begin
                    w_timeout = 1'b1;
                    w_next    = ST_ACK;
                end else begin
                    w_cnt_dec = 1'b1;
                end
`endif
            end
            ST_HOLD: begin
                w_cs_n = 1'b0;
                if (w_cnt_zero) w_next = ST_ACK;
                else            w_cnt_dec = 1'b1;
            end
            ST_ACK: begin
                w_ack  = 1'b1;
                w_next = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!BUF_STATUS) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge WB_CLK_I) begin
        if (WB_RST_I) begin
            r_idx   <= '0;
            r_adr   <= '0;
            r_wdat  <= '0;
            r_rd    <= 1'b0;
            r_rdata <= '0;
            r_dout  <= '0;
`ifdef SPI_SCHED_TIMEOUT_EN
            r_err   <= 1'b0;
`endif
        end else begin
            if ((r_state == ST_IDLE) && BUF_STATUS) begin
                r_adr   <= BUF_DATA_I[REQ_ADR_LSB +: 8];
                r_wdat  <= BUF_DATA_I[REQ_WDAT_LSB +: 32];
                r_rd    <= BUF_DATA_I[REQ_RD_BIT];
                r_idx   <= '0;
                r_rdata <= '0;
            end
            if ((r_state == ST_WAIT) && SPI_DONE) begin
                if (r_rd && (r_idx >= 3'd2)) r_rdata <= {r_rdata[23:0], SPI_RX};
                if (!w_last) r_idx <= r_idx + 3'd1;
            end
            if ((r_state == ST_HOLD) && w_cnt_zero) begin
                r_dout <= '0;
                r_dout[RSP_RDAT_LSB +: 32] <= r_rdata;
                r_dout[RSP_ADR_LSB +: 8]   <= r_adr;
            end
`ifdef SPI_SCHED_TIMEOUT_EN
            if (w_timeout) begin
                r_dout <= {1'b0, 32'hFFFF_FFFF, r_adr};
                r_err  <= 1'b1;
            end
`endif
        end
    end

    assign BUF_DATA_O = r_dout;
    assign BUF_ACK    = w_ack;
    assign SPI_START  = w_start;
    assign SPI_TX     = w_tx;
    assign SPI_CS_N   = w_cs_n;
`ifdef SPI_SCHED_TIMEOUT_EN
    assign ERR        = r_err;
`else
    assign ERR        = 1'b0;
`endif

endmodule

// File: tb/tb_spi_req_sched.sv
// Directed self-checking bench for spi_req_sched with a behavioural byte shifter.
module tb_spi_req_sched;

`ifdef SPI_SCHED_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 8;
`else
    localparam int unsigned TB_TIMEOUT = 1023;
`endif

    logic        clk;
    logic        WB_RST_I;
    logic        BUF_STATUS;
    logic [40:0] BUF_DATA_I;
    logic [40:0] BUF_DATA_O;
    logic        BUF_ACK;
    logic        SPI_START;
    logic [7:0]  SPI_TX;
    logic [7:0]  SPI_RX;
    logic        SPI_DONE;
    logic        SPI_CS_N;
    logic        ERR;

    spi_req_sched #(
        .CS_SETUP (2),
        .CS_HOLD  (2),
        .TIMEOUT  (TB_TIMEOUT)
    ) dut (
        .WB_CLK_I   (clk),
        .WB_RST_I   (WB_RST_I),
        .BUF_STATUS (BUF_STATUS),
        .BUF_DATA_I (BUF_DATA_I),
        .BUF_DATA_O (BUF_DATA_O),
        .BUF_ACK    (BUF_ACK),
        .SPI_START  (SPI_START),
        .SPI_TX     (SPI_TX),
        .SPI_RX     (SPI_RX),
        .SPI_DONE   (SPI_DONE),
        .SPI_CS_N   (SPI_CS_N),
        .ERR        (ERR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic [7:0]  adr;
        logic [31:0] wdat;
        logic [31:0] rx;
        logic [47:0] tx;
        logic [40:0] rsp;
    } vec_t;

    vec_t vecs[5];
    int   n_tests = 0;
    int   n_fail  = 0;

    // shifter model state
    logic [7:0]  tx_log[8];
    int          tx_n      = 0;
    int          sh_wait   = 0;
    int          sh_delay  = 1;
    int          sh_silent = -1;
    int          sh_idx    = 0;
    logic [31:0] cur_rx    = '0;

    always @(negedge clk) begin
        SPI_DONE = 1'b0;
        if (sh_wait > 0) begin
            sh_wait--;
            if (sh_wait == 0) begin
                SPI_DONE = 1'b1;
                SPI_RX   = (sh_idx >= 2) ? cur_rx[8*(5-sh_idx) +: 8] : 8'h00;
            end
        end
        if (SPI_START) begin
            if (tx_n < 8) tx_log[tx_n] = SPI_TX;
            sh_idx = tx_n;
            tx_n++;
            if (sh_idx != sh_silent) sh_wait = sh_delay;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic run_frame(input vec_t v, input int hold_extra, input int silent,
                             input int exp_ack_n, input int exp_tx_n, input logic exp_err);
        int n;
        bit got_ack;
        cur_rx    = v.rx;
        sh_silent = silent;
        tx_n      = 0;
        @(posedge clk); #1;
        BUF_DATA_I = {v.adr, v.wdat, v.rd};
        BUF_STATUS = 1'b1;
        @(posedge clk);
        n = 0;
        got_ack = 1'b0;
        while (n < 200) begin
            @(negedge clk);
            if (n == 0) check("cs_low_after_accept", 64'(SPI_CS_N), 64'd0);
            if (n == 2) begin
                check("first_start", 64'(SPI_START), 64'd1);
                check("first_tx", 64'(SPI_TX), 64'(v.tx[47:40]));
            end
            if (BUF_ACK) begin
                got_ack = 1'b1;
                break;
            end
            @(posedge clk);
            n++;
        end
        check("ack_seen", 64'(got_ack), 64'd1);
        check("ack_cycle", 64'(n), 64'(exp_ack_n));
        check("cs_high_at_ack", 64'(SPI_CS_N), 64'd1);
        check("rsp", 64'(BUF_DATA_O), 64'(v.rsp));
        check("err", 64'(ERR), 64'(exp_err));
        check("tx_count", 64'(tx_n), 64'(exp_tx_n));
        for (int i = 0; i < exp_tx_n; i++)
            check($sformatf("tx_byte%0d", i), 64'(tx_log[i]), 64'(v.tx[8*(5-i) +: 8]));
        @(negedge clk);
        check("ack_width", 64'(BUF_ACK), 64'd0);
        for (int i = 0; i < hold_extra; i++) begin
            @(negedge clk);
            check("held_cs_n", 64'(SPI_CS_N), 64'd1);
            check("held_no_start", 64'(SPI_START), 64'd0);
        end
        @(posedge clk); #1;
        BUF_STATUS = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("gap_cs_n", 64'(SPI_CS_N), 64'd1);
        check("no_extra_tx", 64'(tx_n), 64'(exp_tx_n));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    initial begin
        vec_t tv;
        int   k;
        int   starts;

        vecs[0] = '{rd: 1'b0, adr: 8'h5A, wdat: 32'h1234_5678, rx: 32'h0,
                    tx: 48'h02_5A_12_34_56_78, rsp: 41'h0_0000_0000_5A};
        vecs[1] = '{rd: 1'b1, adr: 8'h10, wdat: 32'h0, rx: 32'hDEAD_BEEF,
                    tx: 48'h03_10_00_00_00_00, rsp: 41'h0_DEAD_BEEF_10};
        vecs[2] = '{rd: 1'b0, adr: 8'hFF, wdat: 32'hA5C3_0F81, rx: 32'h1122_3344,
                    tx: 48'h02_FF_A5_C3_0F_81, rsp: 41'h0_0000_0000_FF};
        vecs[3] = '{rd: 1'b1, adr: 8'h00, wdat: 32'h0, rx: 32'h0180_FF7E,
                    tx: 48'h03_00_00_00_00_00, rsp: 41'h0_0180_FF7E_00};
        vecs[4] = '{rd: 1'b1, adr: 8'h81, wdat: 32'hFFFF_FFFF, rx: 32'h1234_5678,
                    tx: 48'h03_81_00_00_00_00, rsp: 41'h0_1234_5678_81};

        WB_RST_I   = 1'b1;
        BUF_STATUS = 1'b0;
        BUF_DATA_I = '0;
        SPI_RX     = '0;
        SPI_DONE   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cs_n", 64'(SPI_CS_N), 64'd1);
        check("rst_ack", 64'(BUF_ACK), 64'd0);
        check("rst_start", 64'(SPI_START), 64'd0);
        check("rst_tx", 64'(SPI_TX), 64'd0);
        check("rst_dout", 64'(BUF_DATA_O), 64'd0);
        check("rst_err", 64'(ERR), 64'd0);
        @(posedge clk); #1;
        WB_RST_I = 1'b0;

        for (int i = 0; i < 5; i++)
            run_frame(vecs[i], (i == 1) ? 5 : 0, -1, 16, 6, 1'b0);

`ifdef SPI_SCHED_TIMEOUT_EN
        tv = '{rd: 1'b1, adr: 8'h3C, wdat: 32'h0, rx: 32'hCAFE_F00D,
               tx: 48'h03_3C_00_00_00_00, rsp: 41'h0_FFFF_FFFF_3C};
        run_frame(tv, 0, 2, 15, 3, 1'b1);
        run_frame(vecs[0], 0, -1, 16, 6, 1'b1);
`endif

        // reset while byte 3 is in flight, with a slow shifter so DONE lands after reset
        sh_delay  = 3;
        sh_silent = -1;
        cur_rx    = '0;
        @(posedge clk); #1;
        BUF_DATA_I = {8'h77, 32'h0BAD_CAFE, 1'b0};
        BUF_STATUS = 1'b1;
        k = 0;
        starts = 0;
        while (starts < 4 && k < 100) begin
            @(negedge clk);
            if (SPI_START) starts++;
            k++;
        end
        check("reached_byte3", 64'(starts), 64'd4);
        @(posedge clk); #1;
        WB_RST_I   = 1'b1;
        BUF_STATUS = 1'b0;
        @(posedge clk); #1;
        WB_RST_I = 1'b0;
        @(negedge clk);
        check("midrst_cs_n", 64'(SPI_CS_N), 64'd1);
        check("midrst_start", 64'(SPI_START), 64'd0);
        check("midrst_ack", 64'(BUF_ACK), 64'd0);
        check("midrst_dout", 64'(BUF_DATA_O), 64'd0);
        check("midrst_err", 64'(ERR), 64'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_cs_n", 64'(SPI_CS_N), 64'd1);
            check("post_rst_start", 64'(SPI_START), 64'd0);
        end
        sh_delay = 1;
        run_frame(vecs[1], 0, -1, 16, 6, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
